// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes the fetch path must recognise and the
// fetch state encoding.
package cpu_pkg;

  // Opcode that parks the fetch unit until reset.
  localparam logic [7:0] OP_HALT = 8'hFE;

  // Harmless filler instruction; opcode 8'hFF is ignored by the decoder,
  // so presenting it never writes any architectural state.
  localparam logic [43:0] OP_NOP = 44'hFF0_0000_0000;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer in front of a registered-read instruction
// memory. fpc is the address being read; pc tags the instruction that the
// memory returns one cycle later. Supports stall, redirect, pause and halt.
module fetch_unit #(
  parameter int AW = 12,
  parameter int OW = 44
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          stall,
  output logic [AW-1:0] imem_addr,
  input  logic [OW-1:0] imem_rdata,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_we,
  output logic [OW-1:0] op,
  output logic          op_valid,
  output logic [AW-1:0] pc,
  output logic          halted
);

  import cpu_pkg::*;

  // Filler word scaled to the instruction width, opcode kept in the top byte.
  localparam logic [OW-1:0] NOP_OP = {OP_NOP[43:36], {(OW-8){1'b0}}};

  fetch_state_t  state_q;
  logic [AW-1:0] fpc_q;
  logic [AW-1:0] pc_q;
  logic [OW-1:0] hold_op_q;
  logic          hold_valid_q;
  logic [OW-1:0] cur_op;
  logic          is_halt_op;

  // While stalled the memory keeps reading fpc, so its output no longer
  // matches pc; the word captured at stall entry is presented instead.
  assign cur_op     = hold_valid_q ? hold_op_q : imem_rdata;
  assign is_halt_op = (cur_op[OW-1 -: 8] == OP_HALT);

  // Sequencer: state, fetch address, tag pc and the stall hold register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fpc_q        <= '0;
      pc_q         <= '0;
      hold_op_q    <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) state_q <= ST_FILL;
        end
        ST_FILL: begin
          pc_q    <= fpc_q;
          fpc_q   <= fpc_q + AW'(1);
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            if (!hold_valid_q) begin
              hold_op_q    <= imem_rdata;
              hold_valid_q <= 1'b1;
            end
          end else begin
            hold_valid_q <= 1'b0;
            if (is_halt_op) begin
              state_q <= ST_HALT;
            end else if (pc_we) begin
              fpc_q   <= pc_in;
              state_q <= run ? ST_FILL : ST_IDLE;
            end else if (!run) begin
              state_q <= ST_IDLE;
            end else begin
              pc_q  <= fpc_q;
              fpc_q <= fpc_q + AW'(1);
            end
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: only RUN carries a real instruction.
  always_comb begin
    op_valid  = (state_q == ST_RUN);
    halted    = (state_q == ST_HALT);
    op        = op_valid ? cur_op : NOP_OP;
    pc        = pc_q;
    imem_addr = fpc_q;
  end

endmodule
